alu_arbiter: RTL and testbench

//  Shares the single 32-bit MIPS ALU (module alu) between NREQ requesters, e.g. a pipeline EX stage and a multi-cycle unit.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu.sv | 33 +++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and the MIPS ALU.
//   ALU_W        datapath width of the ALU
//   alu_op_t     3-bit ALU function encodings, including the undefined code
//   arb_state_t  arbiter phases IDLE -> EXEC -> RESP
//   alu_req_t    latched operand bundle fed to the ALU
package alu_pkg;

  localparam int unsigned ALU_W  = 32;
  localparam int unsigned ALU_FW = 3;

  typedef enum logic [ALU_FW-1:0] {
    ALU_AND     = 3'b000,
    ALU_OR      = 3'b001,
    ALU_ADD     = 3'b010,
    ALU_ILLEGAL = 3'b011,
    ALU_ANDN    = 3'b100,
    ALU_ORN     = 3'b101,
    ALU_SUB     = 3'b110,
    ALU_SLT     = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    alu_op_t          f;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_req_t;

  // True for the one function code the ALU does not define.
  function automatic logic is_illegal(input alu_op_t f);
    return f == ALU_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit MIPS ALU, purely combinational.
//   i_a, i_b  operands (i_a/i_b treated as signed for SLT)
//   i_f       function code
//   o_y       result; 0 for the undefined code so no X ever leaves the block
//   o_zero    o_y == 0
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  alu_op_t          i_f,
  output logic [ALU_W-1:0] o_y,
  output logic             o_zero
);

  // Function decode; add/sub wrap naturally modulo 2^32.
  always_comb begin
    o_y = '0;
    case (i_f)
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_ADD:  o_y = i_a + i_b;
      ALU_ANDN: o_y = i_a & ~i_b;
      ALU_ORN:  o_y = i_a | ~i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLT:  o_y = ALU_W'($signed(i_a) < $signed(i_b));
      default:  o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
//   clk, reset            rising-edge clock, async active-low reset
//   req_valid/req_ready   request handshake; req_ready is combinational in IDLE
//   req_a/req_b/req_f     packed per-requester operands and function
//   rsp_valid/rsp_ready   response handshake, one-hot on the granted requester
//   rsp_y/rsp_zero/rsp_err shared registered result, 0 outside RESP
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = ALU_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_f,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_y,
  output logic              rsp_zero,
  output logic              rsp_err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic          found;
    logic [PW-1:0] idx;
  } pick_t;

  // First valid requester strictly after ptr, wrapping modulo NREQ.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] valid,
                                    input logic [PW-1:0]   ptr);
    pick_t           p;
    int unsigned     cand;
    logic [NREQ-1:0] rot;
    p = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      rot  = valid >> cand;
      if (!p.found && rot[0]) begin
        p.found = 1'b1;
        p.idx   = PW'(cand);
      end
    end
    return p;
  endfunction

  arb_state_t      r_state;
  logic [PW-1:0]   r_ptr;
  alu_req_t        r_op;
  logic [W-1:0]    r_y;
  logic            r_zero;
  logic            r_err;
  logic [NREQ-1:0] r_rsp_valid;

  pick_t           w_pick;
  alu_req_t        w_req;
  logic [ALU_W-1:0] w_y;
  logic            w_zero;
  logic            w_err;
  logic            w_rsp_done;

  // Winner selection, operand mux and same-cycle grant.
  always_comb begin
    w_pick = rr_pick(req_valid, r_ptr);
    w_req  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pick.idx == PW'(i)) begin
        w_req.a = req_a[i*W +: W];
        w_req.b = req_b[i*W +: W];
        w_req.f = alu_op_t'(req_f[i*3 +: 3]);
      end
    end
    req_ready = '0;
    if (reset && (r_state == IDLE) && w_pick.found) begin
      req_ready = NREQ'(1) << w_pick.idx;
    end
  end

  // ALU sees only the latched operands, never the live request buses.
  alu u_alu (
    .i_a    (r_op.a),
    .i_b    (r_op.b),
    .i_f    (r_op.f),
    .o_y    (w_y),
    .o_zero (w_zero)
  );

  assign w_err      = is_illegal(r_op.f);
  // r_rsp_valid is one-hot on r_ptr, so this picks out rsp_ready[r_ptr].
  assign w_rsp_done = |(rsp_ready & r_rsp_valid);

  // Control FSM with registered result and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= PW'(NREQ - 1);
      r_op        <= '0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick.found) begin
            r_op    <= w_req;
            r_ptr   <= w_pick.idx;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_y         <= w_err ? '0 : W'(w_y);
          r_zero      <= !w_err && w_zero;
          r_err       <= w_err;
          r_rsp_valid <= NREQ'(1) << r_ptr;
          r_state     <= RESP;
        end
        RESP: begin
          // Results clear on exit so the shared bus reads 0 outside RESP.
          if (w_rsp_done) begin
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_y;
  assign rsp_zero  = r_zero;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, multi-cycle sequences,
// and randomized traffic against a reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N = 2;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_f;
  logic [W-1:0]   rsp_y;
  logic           rsp_zero, rsp_err;

  int checks   = 0;
  int failures = 0;
  int last_gnt = N - 1;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_f     (req_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU from the function table.
  function automatic logic [31:0] model_y(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'd4:    return a & ~b;
      3'd5:    return a | ~b;
      3'd6:    return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      3'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference round-robin: first valid index after the last grant.
  function automatic int model_winner(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_f[idx*3 +: 3] = f;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 0);
    chk("rst.rsp_valid", 64'(rsp_valid), 0);
    chk("rst.rsp_y", 64'(rsp_y), 0);
    chk("rst.zero_err", 64'({rsp_zero, rsp_err}), 0);
    reset = 1'b1;
    @(negedge clk);
    last_gnt = N - 1;
  endtask

  // One isolated op from a single requester; called at a negedge with DUT idle.
  task automatic run_single(input string tag, input int idx, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] f, input int stall,
                            input logic [31:0] ey, input logic ez, input logic ee);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    set_req(idx, a, b, f);
    req_valid = oh;
    rsp_ready = '0;
    #1 chk({tag, ".req_ready"}, 64'(req_ready), 64'(oh));
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    chk({tag, ".exec_valid"}, 64'({rsp_valid, rsp_y}), 0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(oh));
    chk({tag, ".rsp_y"}, 64'(rsp_y), 64'(ey));
    chk({tag, ".zero_err"}, 64'({rsp_zero, rsp_err}), 64'({ez, ee}));
    for (int s = 0; s < stall; s++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      chk({tag, ".hold"}, 64'({rsp_valid, rsp_y}), 64'({oh, ey}));
    end
    rsp_ready = oh;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;
    chk({tag, ".release"}, 64'({rsp_valid, rsp_y, rsp_zero, rsp_err}), 0);
    last_gnt = idx;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] ey;
    logic        ez;
    logic        ee;
  } vec_t;

  vec_t tbl[11];

  logic [31:0] ra[N];
  logic [31:0] rb[N];
  logic [2:0]  rf[N];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int           win;
    logic [N-1:0] mask, oh;
    req_a = '0; req_b = '0; req_f = '0;

    tbl[0]  = '{0, 32'd5,          32'd7,          3'b010, 32'd12,         1'b0, 1'b0};
    tbl[1]  = '{1, 32'd9,          32'd9,          3'b110, 32'd0,          1'b1, 1'b0};
    tbl[2]  = '{1, 32'hFFFF_FFFF,  32'd1,          3'b111, 32'd1,          1'b0, 1'b0};
    tbl[3]  = '{0, 32'd3,          32'd4,          3'b011, 32'd0,          1'b0, 1'b1};
    tbl[4]  = '{1, 32'd1,          32'hFFFF_FFFF,  3'b111, 32'd0,          1'b1, 1'b0};
    tbl[5]  = '{0, 32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          1'b1, 1'b0};
    tbl[6]  = '{1, 32'd0,          32'd1,          3'b110, 32'hFFFF_FFFF,  1'b0, 1'b0};
    tbl[7]  = '{0, 32'h0000_F0F0,  32'h0000_FF00,  3'b100, 32'h0000_00F0,  1'b0, 1'b0};
    tbl[8]  = '{1, 32'd0,          32'hFFFF_FFF0,  3'b101, 32'h0000_000F,  1'b0, 1'b0};
    tbl[9]  = '{0, 32'hC,          32'hA,          3'b000, 32'h8,          1'b0, 1'b0};
    tbl[10] = '{1, 32'hC,          32'hA,          3'b001, 32'hE,          1'b0, 1'b0};

    do_reset();

    for (int t = 0; t < 11; t++) begin
      run_single($sformatf("tbl%0d", t), tbl[t].idx, tbl[t].a, tbl[t].b, tbl[t].f,
                 t % 3, tbl[t].ey, tbl[t].ez, tbl[t].ee);
    end

    // Both requesters held valid, results always accepted: strict alternation.
    do_reset();
    set_req(0, 32'd10, 32'd3, 3'b110);
    set_req(1, 32'd6, 32'd12, 3'b001);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      oh = N'(1) << (k % 2);
      #1 chk($sformatf("rr%0d.grant", k), 64'(req_ready), 64'(oh));
      @(negedge clk);
      chk($sformatf("rr%0d.exec", k), 64'({req_ready, rsp_valid}), 0);
      @(negedge clk);
      chk($sformatf("rr%0d.rsp_valid", k), 64'(rsp_valid), 64'(oh));
      chk($sformatf("rr%0d.rsp_y", k), 64'(rsp_y), (k % 2 == 0) ? 64'd7 : 64'd14);
      if (k == 3) req_valid = '0;
      @(negedge clk);
    end
    rsp_ready = '0;
    chk("rr.idle", 64'({rsp_valid, req_ready}), 0);
    last_gnt = 1;

    // Requester 1 stalls its response while requester 0 waits.
    set_req(1, 32'd20, 32'd22, 3'b010);
    req_valid = 2'b10;
    #1 chk("stall.grant1", 64'(req_ready), 64'b10);
    @(posedge clk); @(negedge clk);
    set_req(0, 32'hFF, 32'h0F, 3'b000);
    req_valid = 2'b01;
    chk("stall.exec_ready", 64'(req_ready), 0);
    @(posedge clk); @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      rsp_ready = 2'b01;
      chk($sformatf("stall%0d.hold", s), 64'({rsp_valid, req_ready, rsp_y}),
          64'({2'b10, 2'b00, 32'd42}));
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;
    chk("stall.grant0", 64'(req_ready), 64'b01);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("stall.rsp0", 64'({rsp_valid, rsp_y}), 64'({2'b01, 32'h0F}));
    rsp_ready = 2'b01;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;
    last_gnt = 0;

    // Reset during EXEC drops the op; pointer returns to favour requester 0.
    set_req(0, 32'd1, 32'd2, 3'b010);
    set_req(1, 32'd4, 32'd4, 3'b010);
    req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    req_valid = 2'b11;
    #2 reset = 1'b0;
    #1 chk("midrst.outputs", 64'({req_ready, rsp_valid, rsp_y, rsp_zero, rsp_err}), 0);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 2'b11;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("midrst.no_rsp%0d", s), 64'(rsp_valid), 0);
    end
    rsp_ready = '0;
    req_valid = 2'b11;
    #1 chk("midrst.grant0", 64'(req_ready), 64'b01);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("midrst.rsp", 64'({rsp_valid, rsp_y}), 64'({2'b01, 32'd3}));
    rsp_ready = 2'b01;
    @(posedge clk); @(negedge clk);
    rsp_ready = '0;
    last_gnt = 0;

    // Randomized contention against the reference model.
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) begin
        ra[i] = $urandom;
        rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
        rf[i] = 3'($urandom_range(0, 7));
        set_req(i, ra[i], rb[i], rf[i]);
      end
      req_valid = mask;
      win = model_winner(mask, last_gnt);
      oh  = N'(1) << win;
      #1 chk($sformatf("rnd%0d.grant", it), 64'(req_ready), 64'(oh));
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      chk($sformatf("rnd%0d.exec", it), 64'(rsp_valid), 0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("rnd%0d.rsp", it),
          64'({rsp_valid, rsp_y, rsp_zero, rsp_err}),
          64'({oh, model_y(ra[win], rb[win], rf[win]),
               (rf[win] != 3'b011) && (model_y(ra[win], rb[win], rf[win]) == 32'd0),
               rf[win] == 3'b011}));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rsp_ready = oh;
      @(posedge clk); @(negedge clk);
      rsp_ready = '0;
      last_gnt = win;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
